// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART transmit path:
//                FSM state encoding, data width and bit-period computation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Width of one UART character.
    localparam int DATA_WIDTH = 8;

    // FSM states. PARITY is only entered when UART_TX_PARITY_EN is defined,
    // but the encoding is kept fixed so both builds share one state map.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per line bit. Integer division: the residual bit-rate
    // error is accepted.
    function automatic int calc_baud_tick(input int clk_speed, input int baud_rate);
        return clk_speed / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Bit-period counter. Counts 0..BAUD_TICK-1 while enabled and
//                wraps to 0 at the end of every bit period.
//  Ports       : clock   - system clock (rising edge)
//                clear   - synchronous clear of the tick counter
//                en      - count enable (high while a frame is in flight)
//                bit_end - high in the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int BAUD_TICK = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int BAUD_TICK_WIDTH = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
    localparam logic [BAUD_TICK_WIDTH-1:0] c_tick_last = BAUD_TICK_WIDTH'(BAUD_TICK - 1);

    logic [BAUD_TICK_WIDTH-1:0] tick_q;
    logic [BAUD_TICK_WIDTH-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clear) begin
            tick_d = '0;
        end else if (en) begin
            // Wrap on the terminal count so the value never reaches BAUD_TICK.
            tick_d = (tick_q == c_tick_last) ? '0 : tick_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        tick_q <= tick_d;
    end

    assign bit_end = en && (tick_q == c_tick_last);

endmodule
`default_nettype wire

// File: rtl/uart_transmit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_transmit
//  Description : UART transmitter. Accepts a byte on a send/ready handshake
//                and serialises it as start bit, 8 data bits LSB first,
//                optional even parity bit, one stop bit.
//  Build macro : UART_TX_PARITY_EN - adds an even parity bit after data bit 7
//  Ports       : clock         - system clock (rising edge)
//                reset         - synchronous, active-high reset
//                dataIn[7:0]   - byte to send, sampled on the accept cycle
//                send          - valid; accepted when send && ready
//                ready         - high only while idle
//                tx            - registered serial line, idles high
//                finished_send - pulse in the last cycle of the stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLK_SPEED = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  send,
    output logic                  ready,
    output logic                  tx,
    output logic                  finished_send
);

    localparam int BAUD_TICK = calc_baud_tick(CLK_SPEED, BAUD_RATE);
    localparam int BITCNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [BITCNT_WIDTH-1:0] c_last_bit = BITCNT_WIDTH'(DATA_WIDTH - 1);

    generate
        if (BAUD_TICK < 2) begin : g_bad_baud_tick
            $error("uart_transmit: CLK_SPEED/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e              state_q;
    uart_state_e              state_d;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic [DATA_WIDTH-1:0]    shift_d;
    logic [BITCNT_WIDTH-1:0]  bitcnt_q;
    logic [BITCNT_WIDTH-1:0]  bitcnt_d;
    logic                     tx_q;
    logic                     tx_d;
`ifdef UART_TX_PARITY_EN
    logic                     parity_q;
    logic                     parity_d;
`endif

    logic accept;
    logic bit_end;
    logic cnt_clear;
    logic cnt_en;

    // ------------------------------------------------------------------
    // Bit-period timing
    // ------------------------------------------------------------------
    assign cnt_clear = reset || accept;
    assign cnt_en    = (state_q != IDLE);

    uart_baud_counter #(
        .BAUD_TICK (BAUD_TICK)
    ) u_baud_counter (
        .clock   (clock),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .bit_end (bit_end)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        accept   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (send) begin
                    accept   = 1'b1;
                    state_d  = START;
                    shift_d  = dataIn;
                    bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    // The shift register empties as bits go out, so the
                    // parity is captured together with the byte.
                    parity_d = ^dataIn;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d  = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is computed from the next state so that tx can be
        // registered without lagging the FSM by a cycle.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx    = tx_q;
    assign ready = (state_q == IDLE);
    // A reset landing on the last stop cycle abandons the frame, so the
    // completion pulse is suppressed in that cycle.
    assign finished_send = (state_q == STOP) && bit_end && !reset;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmit
//  Description : Directed self-checking bench for uart_transmit with
//                CLK_SPEED=16, BAUD_RATE=1 (16 cycles per bit).
//  Build macro : UART_TX_PARITY_EN - enables the parity scenario and the
//                11-bit frame expectation
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmit;

    localparam int TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * TICK;
`else
    localparam int FRAME = 10 * TICK;
`endif

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       send   = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       ready;
    logic       tx;
    logic       finished_send;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_transmit #(
        .CLK_SPEED (16),
        .BAUD_RATE (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dataIn        (dataIn),
        .send          (send),
        .ready         (ready),
        .tx            (tx),
        .finished_send (finished_send)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected line level in cycle n (1-based) of a frame carrying b.
    function automatic logic exp_tx(input logic [7:0] b, input int n);
        int idx;
        idx = (n - 1) / TICK;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        send  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1 || finished_send !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: tx=%b ready=%b finished=%b, required 1 1 0",
                         tx, ready, finished_send);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || finished_send !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: tx=%b ready=%b finished=%b, required 1 1 0",
                     tx, ready, finished_send);
        end
    endtask

    task automatic test_frame_55();
        dataIn = 8'h55;
        send   = 1'b1;
        step();
        send   = 1'b0;
        dataIn = 8'h00;
        for (int n = 1; n <= FRAME; n++) begin
            checks++;
            if (tx !== exp_tx(8'h55, n)) begin
                errors++;
                $display("FAIL frame55_tx cycle %0d: tx=%b, required %b", n, tx, exp_tx(8'h55, n));
            end
            checks++;
            if (finished_send !== (n == FRAME)) begin
                errors++;
                $display("FAIL frame55_finished cycle %0d: finished=%b, required %b",
                         n, finished_send, (n == FRAME));
            end
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL frame55_busy cycle %0d: ready=%b, required 0", n, ready);
            end
            if (n < FRAME) step();
        end
        step();
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1 || finished_send !== 1'b0) begin
            errors++;
            $display("FAIL frame55_idle: ready=%b tx=%b finished=%b, required 1 1 0",
                     ready, tx, finished_send);
        end
    endtask

    task automatic test_busy_ignore();
        dataIn = 8'hA3;
        send   = 1'b1;
        step();
        send   = 1'b0;
        for (int n = 1; n <= FRAME; n++) begin
            // Mid data bit 4: offer a new byte and change dataIn.
            if (n == 85) begin
                send   = 1'b1;
                dataIn = 8'hFF;
            end
            if (n == 100) send = 1'b0;
            checks++;
            if (tx !== exp_tx(8'hA3, n)) begin
                errors++;
                $display("FAIL busy_tx cycle %0d: tx=%b, required %b", n, tx, exp_tx(8'hA3, n));
            end
            if (n < FRAME) step();
        end
        dataIn = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (ready !== 1'b1 || tx !== 1'b1) begin
                errors++;
                $display("FAIL busy_no_queue idle cycle %0d: ready=%b tx=%b, required 1 1",
                         i, ready, tx);
            end
        end
    endtask

    task automatic test_reset_mid();
        dataIn = 8'h0F;
        send   = 1'b1;
        step();
        send   = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            checks++;
            if (tx !== exp_tx(8'h0F, n) || finished_send !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_pre cycle %0d: tx=%b finished=%b, required %b 0",
                         n, tx, finished_send, exp_tx(8'h0F, n));
            end
            if (n < 70) step();
        end
        // Cycle 70 lies inside data bit 3.
        reset = 1'b1;
        step();
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || finished_send !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: tx=%b ready=%b finished=%b, required 1 1 0",
                     tx, ready, finished_send);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1 || finished_send !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_idle cycle %0d: tx=%b ready=%b finished=%b, required 1 1 0",
                         i, tx, ready, finished_send);
            end
        end
        dataIn = 8'h3C;
        send   = 1'b1;
        step();
        send   = 1'b0;
        for (int n = 1; n <= FRAME; n++) begin
            checks++;
            if (tx !== exp_tx(8'h3C, n) || finished_send !== (n == FRAME)) begin
                errors++;
                $display("FAIL rstmid_next cycle %0d: tx=%b finished=%b, required %b %b",
                         n, tx, finished_send, exp_tx(8'h3C, n), (n == FRAME));
            end
            if (n < FRAME) step();
        end
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: ready=%b, required 1", ready);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par   [2];
        bytes[0] = 8'h07; par[0] = 1'b1;
        bytes[1] = 8'h03; par[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dataIn = bytes[k];
            send   = 1'b1;
            step();
            send   = 1'b0;
            for (int n = 1; n <= FRAME; n++) begin
                checks++;
                if (tx !== exp_tx(bytes[k], n) || finished_send !== (n == FRAME)) begin
                    errors++;
                    $display("FAIL parity_frame byte %h cycle %0d: tx=%b finished=%b, required %b %b",
                             bytes[k], n, tx, finished_send, exp_tx(bytes[k], n), (n == FRAME));
                end
                if (n == 9 * TICK + 8) begin
                    checks++;
                    if (tx !== par[k]) begin
                        errors++;
                        $display("FAIL parity_bit byte %h: tx=%b, required %b", bytes[k], tx, par[k]);
                    end
                end
                if (n < FRAME) step();
            end
            step();
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL parity_ready byte %h: ready=%b, required 1", bytes[k], ready);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        logic [7:0] rx;
        int         fin_cnt;
        bytes[0] = 8'h81;
        bytes[1] = 8'h7E;
        fin_cnt  = 0;
        dataIn   = bytes[0];
        send     = 1'b1;
        step();
        dataIn   = bytes[1];
        for (int k = 0; k < 2; k++) begin
            rx = 8'h00;
            for (int n = 1; n <= FRAME; n++) begin
                if (k == 1 && n == 2) send = 1'b0;
                if (finished_send === 1'b1) fin_cnt++;
                // Mid-bit sampling, as a receiver would.
                if (n > TICK && n <= 9 * TICK && ((n - 1) % TICK) == TICK / 2)
                    rx[(n - 1) / TICK - 1] = tx;
                checks++;
                if (tx !== exp_tx(bytes[k], n)) begin
                    errors++;
                    $display("FAIL b2b_tx frame %0d cycle %0d: tx=%b, required %b",
                             k, n, tx, exp_tx(bytes[k], n));
                end
                step();
            end
            checks++;
            if (rx !== bytes[k]) begin
                errors++;
                $display("FAIL b2b_loopback frame %0d: received %h, required %h", k, rx, bytes[k]);
            end
            // Exactly one idle cycle between frames.
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap frame %0d: tx=%b ready=%b, required 1 1", k, tx, ready);
            end
            if (k == 0) begin
                step();
                checks++;
                if (tx !== 1'b0 || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_restart: tx=%b ready=%b, required 0 0", tx, ready);
                end
            end
        end
        checks++;
        if (fin_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_finished_count: saw %0d pulses, required 2", fin_cnt);
        end
        step();
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end_idle: tx=%b ready=%b, required 1 1", tx, ready);
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_busy_ignore();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
